accum_sq_iter: RTL and testbench

Iterated modular squaring controller for the VDF datapath. Accepts a starting value x and an iteration count T, then drives the modular multiplier with (x, x) repeatedly, feeding each result back as the next operand. It returns x^(2^T) mod MODULUS once all T squarings are done. It sits directly upstream of the multiplier and owns both of its stream ports: it issues the requests and consumes the results.

---
 rtl/accum_sq_iter_if.sv | 26 ++
 rtl/accum_sq_iter.sv | 138 +++++++++++++
 tb/tb_accum_sq_iter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_sq_iter_if.sv
// Request/result stream between the squaring controller and the modular multiplier.
// The controller drives requests and consumes results, so it takes the master side.
interface accum_sq_iter_if #(
    parameter int BITS     = 381,
    parameter int CTL_BITS = 8
);
    logic                req_val;
    logic                req_rdy;
    logic [BITS-1:0]     req_dat_a;
    logic [BITS-1:0]     req_dat_b;
    logic [CTL_BITS-1:0] req_ctl;
    logic                res_val;
    logic                res_rdy;
    logic [BITS-1:0]     res_dat;
    logic [CTL_BITS-1:0] res_ctl;

    modport master (
        output req_val, req_dat_a, req_dat_b, req_ctl, res_rdy,
        input  req_rdy, res_val, res_dat, res_ctl
    );

    modport slave (
        input  req_val, req_dat_a, req_dat_b, req_ctl, res_rdy,
        output req_rdy, res_val, res_dat, res_ctl
    );
endinterface

// File: rtl/accum_sq_iter.sv
// Iterated modular squaring controller: computes x^(2^T) mod MODULUS by issuing
// T back-to-back squarings to an external multiplier, one request outstanding at a time.
module accum_sq_iter #(
    parameter int BITS     = 381,
    parameter int ITER_W   = 32,
    parameter int CTL_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_val,
    output logic                 o_rdy,
    input  logic [BITS-1:0]      i_dat,
    input  logic [ITER_W-1:0]    i_iter,
    accum_sq_iter_if.master      mul,
    output logic                 o_val,
    input  logic                 i_rdy,
    output logic [BITS-1:0]      o_dat,
    output logic [ITER_W-1:0]    o_cnt,
    output logic                 o_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [BITS-1:0]       acc_r, acc_s;
    logic [ITER_W-1:0]     iter_r, iter_s;
    logic [ITER_W-1:0]     cnt_r, cnt_s, cnt_inc_s;
    logic                  err_r, err_s;
    logic [CTL_BITS-1:0]   ctl_r;
    logic                  rdy_r, val_r, mul_val_r, mul_rdy_r;

    // Tag is the low CTL_BITS of the count; zero-extend first so CTL_BITS > ITER_W also works.
    function automatic logic [CTL_BITS-1:0] tag_of(input logic [ITER_W-1:0] cnt);
        logic [ITER_W+CTL_BITS-1:0] ext;
        ext = {{CTL_BITS{1'b0}}, cnt};
        return ext[CTL_BITS-1:0];
    endfunction

    // Next-state and datapath update for the squaring loop.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        iter_s    = iter_r;
        cnt_s     = cnt_r;
        err_s     = err_r;
        cnt_inc_s = cnt_r + {{(ITER_W-1){1'b0}}, 1'b1};
        case (state_r)
            ST_IDLE: begin
                if (i_val) begin
                    acc_s  = i_dat;
                    iter_s = i_iter;
                    cnt_s  = {ITER_W{1'b0}};
                    err_s  = 1'b0;
                    state_s = (i_iter == {ITER_W{1'b0}}) ? ST_OUT : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mul.req_rdy) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mul.res_val) begin
                    acc_s = mul.res_dat;
                    cnt_s = cnt_inc_s;
                    // A wrong tag is only flagged; the returned value is still taken.
                    if (mul.res_ctl != tag_of(cnt_r)) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    state_s = (cnt_inc_s == iter_r) ? ST_OUT : ST_ISSUE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (i_rdy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake flags decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            acc_r     <= {BITS{1'b0}};
            iter_r    <= {ITER_W{1'b0}};
            cnt_r     <= {ITER_W{1'b0}};
            err_r     <= 1'b0;
            ctl_r     <= {CTL_BITS{1'b0}};
            rdy_r     <= 1'b1;
            val_r     <= 1'b0;
            mul_val_r <= 1'b0;
            mul_rdy_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            iter_r    <= iter_s;
            cnt_r     <= cnt_s;
            err_r     <= err_s;
            ctl_r     <= tag_of(cnt_s);
            rdy_r     <= (state_s == ST_IDLE);
            val_r     <= (state_s == ST_OUT);
            mul_val_r <= (state_s == ST_ISSUE);
            // Results are also drained in IDLE so a stale one left by a reset cannot stall the multiplier.
            mul_rdy_r <= (state_s == ST_WAIT) || (state_s == ST_IDLE);
        end
    end

    assign o_rdy         = rdy_r;
    assign o_val         = val_r;
    assign o_dat         = acc_r;
    assign o_cnt         = cnt_r;
    assign o_err         = err_r;
    assign mul.req_val   = mul_val_r;
    assign mul.req_dat_a = acc_r;
    assign mul.req_dat_b = acc_r;
    assign mul.req_ctl   = ctl_r;
    assign mul.res_rdy   = mul_rdy_r;

endmodule

// File: tb/tb_accum_sq_iter.sv
// Scoreboard bench for accum_sq_iter with a behavioural modular multiplier
// (modulus 2^61-1, configurable latency, random stalls) and a power reference model.
module tb_accum_sq_iter;
    localparam int BITS     = 61;
    localparam int ITER_W   = 5;
    localparam int CTL_BITS = 3;
    localparam logic [BITS-1:0] MODV = 61'h1FFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [BITS-1:0] dat;
        int              cnt;
        bit              err;
        int              acc_cyc;
        bit              chk_lat;
        int              lat;
    } exp_t;

    logic              clk;
    logic              i_rst;
    logic              i_val;
    logic              o_rdy;
    logic [BITS-1:0]   i_dat;
    logic [ITER_W-1:0] i_iter;
    logic              o_val;
    logic              i_rdy;
    logic [BITS-1:0]   o_dat;
    logic [ITER_W-1:0] o_cnt;
    logic              o_err;

    accum_sq_iter_if #(.BITS(BITS), .CTL_BITS(CTL_BITS)) mul_bus ();

    accum_sq_iter #(.BITS(BITS), .ITER_W(ITER_W), .CTL_BITS(CTL_BITS)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy), .i_dat(i_dat),
        .i_iter(i_iter), .mul(mul_bus), .o_val(o_val), .i_rdy(i_rdy), .o_dat(o_dat),
        .o_cnt(o_cnt), .o_err(o_err)
    );

    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    exp_t sb[$];

    int  lat        = 1;
    bit  stall_en   = 1'b0;
    bit  corrupt_en = 1'b0;
    bit  pend       = 1'b0;
    int  req_idx    = 0;
    int  due        = 0;
    logic [BITS-1:0]     pend_dat;
    logic [CTL_BITS-1:0] pend_ctl;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BITS-1:0] mulmod(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [2*BITS-1:0] p;
        logic [2*BITS-1:0] r;
        p = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
        r = p % {{BITS{1'b0}}, MODV};
        return r[BITS-1:0];
    endfunction

    // x^(2^t) mod MODV: squaring t times is exponentiation by 2^t.
    function automatic logic [BITS-1:0] ref_pow(input logic [BITS-1:0] x, input int t);
        logic [BITS-1:0] r;
        r = x;
        for (int i = 0; i < t; i++) r = mulmod(r, r);
        return r;
    endfunction

    // Behavioural multiplier: one pending result, delivered lat cycles after the request.
    initial begin
        mul_bus.req_rdy = 1'b0;
        mul_bus.res_val = 1'b0;
        mul_bus.res_dat = '0;
        mul_bus.res_ctl = '0;
        forever begin
            @(negedge clk);
            if (o_rdy) req_idx = 0;
            if (pend && cyc >= due && !(stall_en && $urandom_range(0, 2) == 0)) begin
                mul_bus.res_val = 1'b1;
                mul_bus.res_dat = pend_dat;
                mul_bus.res_ctl = (corrupt_en && pend_ctl == 1) ? (pend_ctl ^ {CTL_BITS{1'b1}}) : pend_ctl;
                if (mul_bus.res_rdy) pend = 1'b0;
            end else begin
                mul_bus.res_val = 1'b0;
            end
            mul_bus.req_rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mul_bus.req_val && mul_bus.req_rdy) begin
                chk("one_outstanding", pend, 0);
                chk("dat_a_eq_b", mul_bus.req_dat_b, mul_bus.req_dat_a);
                chk("req_tag", mul_bus.req_ctl, req_idx % (1 << CTL_BITS));
                pend     = 1'b1;
                pend_dat = mulmod(mul_bus.req_dat_a, mul_bus.req_dat_a);
                pend_ctl = mul_bus.req_ctl;
                due      = cyc + lat;
                req_idx++;
            end
        end
    end

    // Output monitor: pops the scoreboard on each o_val/i_rdy handshake.
    initial begin
        bit              held;
        logic [BITS-1:0] held_dat;
        exp_t            e;
        held  = 1'b0;
        i_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (o_val) begin
                if (held) chk("hold_dat", o_dat, held_dat);
                if (sb.size() > 0) chk("err_in_out", o_err, sb[0].err);
                i_rdy = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
                if (i_rdy) begin
                    held = 1'b0;
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_dat", o_dat, e.dat);
                        chk("out_cnt", o_cnt, e.cnt);
                        chk("req_count", req_idx, e.cnt);
                        if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 1 + e.cnt * (e.lat + 1));
                    end
                end else begin
                    held     = 1'b1;
                    held_dat = o_dat;
                end
            end else begin
                if (held) chk("val_dropped", o_val, 1);
                held  = 1'b0;
                i_rdy = 1'(($urandom_range(0, 1)));
            end
        end
    end

    task automatic send(input logic [BITS-1:0] x, input int t, input bit lat_chk, input bit err_exp);
        int   w;
        exp_t e;
        w = 0;
        i_val  = 1'b1;
        i_dat  = x;
        i_iter = t[ITER_W-1:0];
        while (!o_rdy && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) chk("accept_timeout", 1, 0);
        e.dat = ref_pow(x, t); e.cnt = t; e.err = err_exp;
        e.acc_cyc = cyc; e.chk_lat = lat_chk; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        i_val  = 1'b0;
        i_dat  = BITS'($urandom());
        chk("rdy_low_after_accept", o_rdy, 0);
        chk("err_clear_on_accept", o_err, 0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w;
        logic [BITS-1:0] x;
        i_rst  = 1'b1;
        i_val  = 1'b0;
        i_dat  = '0;
        i_iter = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", o_rdy, 1);
        chk("rst_val", o_val, 0);
        chk("rst_mul_val", mul_bus.req_val, 0);
        chk("rst_mul_rdy", mul_bus.res_rdy, 1);
        chk("rst_dat", o_dat, 0);
        chk("rst_dat_a", mul_bus.req_dat_a, 0);
        chk("rst_dat_b", mul_bus.req_dat_b, 0);
        chk("rst_ctl", mul_bus.req_ctl, 0);
        chk("rst_cnt", o_cnt, 0);
        chk("rst_err", o_err, 0);
        i_rst = 1'b0;
        @(negedge clk);

        lat = 4; send(61'd5, 0, 1'b1, 1'b0); drain();
        lat = 4; send(61'd2, 3, 1'b1, 1'b0); drain();
        chk("t3_value", o_dat, 256);
        chk("cnt_held_idle", o_cnt, 3);
        lat = 2; send(MODV - 61'd1, 1, 1'b1, 1'b0); drain();
        chk("t1_neg_one", o_dat, 1);

        lat = 3; corrupt_en = 1'b1; send(61'd7, 4, 1'b1, 1'b1); drain();
        corrupt_en = 1'b0;
        chk("err_sticky_idle", o_err, 1);

        // Reset while WAITing; the abandoned result arrives once the block is IDLE.
        lat = 6; send(61'd11, 2, 1'b0, 1'b0);
        w = 0;
        while (!pend && w < 100) begin @(negedge clk); w++; end
        chk("req_before_reset", pend, 1);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        sb.delete();
        chk("midrst_rdy", o_rdy, 1);
        chk("midrst_val", o_val, 0);
        w = 0;
        while (pend && w < 100) begin @(negedge clk); w++; end
        chk("stale_consumed", pend, 0);
        @(negedge clk);
        chk("stale_rdy", o_rdy, 1);
        chk("stale_err", o_err, 0);
        chk("stale_cnt", o_cnt, 0);
        lat = 2; send(61'd3, 2, 1'b1, 1'b0); drain();
        chk("after_stale_81", o_dat, 81);

        stall_en = 1'b1;
        for (int j = 0; j < 200; j++) begin
            x   = {$urandom(), $urandom()} % MODV;
            lat = $urandom_range(1, 4);
            send(x, $urandom_range(0, 20), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        stall_en = 1'b0;

        lat = 1; send(61'd2, (1 << ITER_W) - 1, 1'b1, 1'b0); drain();
        chk("tmax_cnt", o_cnt, (1 << ITER_W) - 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
